jump_charge_ctl: RTL
====================

Name: jump_charge_ctl

Overview:
- Sequences the player jump for the game controller.
- While space is held, it builds jump velocity from a frame tick. On release it latches velocity and direction and hands them to the physics/position datapath through a req/ack handshake.
- It then tracks the airborne phase and a post-landing cooldown before another charge is allowed.
- It sits between keyboard decode and the character physics/collision logic; it also drives charge status to skin selection.

Parameters:
- VEL_W, 6, width of jump_vel.
- VEL_MIN, 4, velocity loaded at charge start.
- VEL_MAX, 20, saturation velocity; must satisfy VEL_MIN <= VEL_MAX < 2**VEL_W.
- STEP_TICKS, 3, ticks per +1 velocity increment; must be >= 1.
- LAND_TICKS, 8, cooldown ticks after landing.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle frame strobe; all timing counts use it
- key_space  in  1  charge/jump key, level
- key_left  in  1  left key, level
- key_right  in  1  right key, level
- grounded  in  1  bottom collision from physics, level
- launch_ack  in  1  physics accepted launch, one-cycle pulse
- launch_req  out  1  launch request; held until ack
- jump_vel  out  VEL_W  latched launch velocity; charge value while charging
- jump_dir  out  2  00 vertical, 01 left, 10 right
- charging  out  1  high in CHARGE
- busy  out  1  high in LAUNCH, AIRBORNE or LAND

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE; launch_req 0; jump_vel 0; jump_dir 00; charging 0; busy 0; all counters 0. Reset mid-handshake drops launch_req in the same edge with no ack required.
- States: IDLE, CHARGE, LAUNCH, AIRBORNE, LAND. All outputs are registered.
- IDLE:
  - grounded=0 → AIRBORNE (walk-off).
  - Otherwise key_space=1 and grounded=1 → CHARGE, with jump_vel=VEL_MIN and step counter 0.
  - Entry happens on any cycle, not only on ticks.
- CHARGE:
  - On each tick with key_space=1, the step counter increments.
  - When the counter reaches STEP_TICKS-1, it clears and jump_vel increments, saturating at VEL_MAX.
  - key_space=0 (sampled every cycle) → LAUNCH. jump_dir is latched from keys on that same cycle: left-only 01, right-only 10, both or none 00. jump_vel freezes.
  - grounded=0 overrides release: → AIRBORNE, jump_vel←0, charge discarded, no launch_req.
- LAUNCH:
  - launch_req=1, with jump_vel and jump_dir stable.
  - launch_ack=1 → launch_req←0 next cycle, → AIRBORNE.
  - An ack arriving in the same cycle req first rises is honoured.
  - An ack outside LAUNCH is ignored.
- AIRBORNE:
  - Must observe grounded=0 at least once (an armed flag), then grounded=1 → LAND with the cooldown counter cleared.
  - If grounded never drops, it waits indefinitely.
- LAND:
  - Counts LAND_TICKS ticks; then → IDLE with jump_vel←0 and jump_dir←00.
  - key_space held through the LAND→IDLE transition does not start a charge; a fresh 0→1 edge of key_space is required. A space-released flag is kept for this.
  - grounded=0 during LAND → AIRBORNE with the flag armed.
- Simultaneous events: grounded loss beats key events. Release plus tick in the same cycle means no increment, then LAUNCH.
- Arithmetic: unsigned, saturating. The step counter width is $clog2(STEP_TICKS)+1. The cooldown counter width is $clog2(LAND_TICKS)+1.

Optional Feature:
- Macro JUMP_AUTO_LAUNCH_EN.
- Defined: in CHARGE, once jump_vel=VEL_MAX and a further STEP_TICKS ticks elapse with key still held, the block goes → LAUNCH as if released. Direction is latched at that cycle.
- Undefined: charge holds at VEL_MAX until release.

Decomposition:
- Shared package jump_king_pkg holds:
  - the typedef enum logic [2:0] jump_phase_t (IDLE, CHARGE, LAUNCH, AIRBORNE, LAND);
  - localparams DIR_NONE=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10.
- One natural sub-module, tick_counter: a tick-enabled counter with clear and terminal-count output. It is instantiated for the charge step and the landing cooldown.
- The FSM and output registers stay in jump_charge_ctl.

Test Plan:
- Reset: rst high 2 cycles with key_space=1 → all outputs 0, state IDLE. After rst drops with key_space still held: no CHARGE until key_space 0→1.
- Charge ramp: key_space=1 for 9 ticks (STEP_TICKS=3), then release with key_right=1 → jump_vel=7, launch_req=1, jump_dir=10.
- Saturation: hold 60 ticks, release with no direction → jump_vel=20, jump_dir=00. With JUMP_AUTO_LAUNCH_EN: launch_req rises at tick 51 with key still held.
- Handshake: delay launch_ack 5 cycles → launch_req stays 1 with vel/dir unchanged. It drops the cycle after ack; state AIRBORNE.
- Landing: grounded 0 for 20 cycles then 1 → LAND, busy=1 for 8 ticks, then IDLE with jump_vel=0. A second space press then charges.
- Walk-off: grounded→0 during CHARGE at jump_vel=6 → AIRBORNE, jump_vel=0, launch_req never asserted.

Source files
------------

// File: rtl/jump_king_pkg.sv
// Shared types and constants for the jump sequencer: FSM phase encoding and
// launch direction codes.
package jump_king_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
    LAUNCH,
    AIRBORNE,
    LAND
  } jump_phase_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Opposing or absent direction keys give a vertical jump.
  function automatic logic [1:0] key_dir(input logic left, input logic right);
    if (left && !right) begin
      return DIR_LEFT;
    end else if (right && !left) begin
      return DIR_RIGHT;
    end
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/jump_charge_ctl_if.sv
// Launch handshake between the jump sequencer (master) and the physics
// datapath (slave).
interface jump_charge_ctl_if #(
  parameter int unsigned VEL_W = 6
);
  logic             launch_req;
  logic             launch_ack;
  logic [VEL_W-1:0] jump_vel;
  logic [1:0]       jump_dir;

  modport master (
    output launch_req,
    output jump_vel,
    output jump_dir,
    input  launch_ack
  );

  modport slave (
    input  launch_req,
    input  jump_vel,
    input  jump_dir,
    output launch_ack
  );
endinterface

// File: rtl/tick_counter.sv
// Tick-enabled wrapping counter with synchronous clear; tc pulses on the
// enabled cycle where the count wraps from MAX_COUNT back to zero.
module tick_counter #(
  parameter int unsigned MAX_COUNT = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc = en && !clr && (count_q == LastVal);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/jump_charge_ctl.sv
// Jump sequencer: charges velocity while space is held, hands it to physics via
// req/ack, then tracks airborne and landing cooldown. Optional JUMP_AUTO_LAUNCH_EN.
module jump_charge_ctl
  import jump_king_pkg::*;
#(
  parameter int unsigned VEL_W      = 6,
  parameter int unsigned VEL_MIN    = 4,
  parameter int unsigned VEL_MAX    = 20,
  parameter int unsigned STEP_TICKS = 3,
  parameter int unsigned LAND_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              key_space,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              grounded,
  jump_charge_ctl_if.master phys,
  output logic              charging,
  output logic              busy
);

  localparam logic [VEL_W-1:0] VelMin = VEL_W'(VEL_MIN);
  localparam logic [VEL_W-1:0] VelMax = VEL_W'(VEL_MAX);

  jump_phase_t      state_q, state_d;
  logic [VEL_W-1:0] jump_vel_q, jump_vel_d;
  logic [1:0]       jump_dir_q, jump_dir_d;
  logic             launch_req_q, charging_q, busy_q;
  logic             armed_q, armed_d;
  logic             space_rel_q;
  logic             step_tc, land_tc;

  tick_counter #(
    .MAX_COUNT(STEP_TICKS - 1),
    .CNT_W    ($clog2(STEP_TICKS) + 1)
  ) u_step_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q != CHARGE),
    .en (state_q == CHARGE && tick && key_space),
    .tc (step_tc)
  );

  tick_counter #(
    .MAX_COUNT(LAND_TICKS - 1),
    .CNT_W    ($clog2(LAND_TICKS) + 1)
  ) u_land_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q != LAND),
    .en (state_q == LAND && tick),
    .tc (land_tc)
  );

  always_comb begin
    state_d    = state_q;
    jump_vel_d = jump_vel_q;
    jump_dir_d = jump_dir_q;
    armed_d    = armed_q;
    unique case (state_q)
      IDLE: begin
        if (!grounded) begin
          state_d = AIRBORNE;
          armed_d = 1'b1;
        end else if (key_space && space_rel_q) begin
          state_d    = CHARGE;
          jump_vel_d = VelMin;
        end
      end
      CHARGE: begin
        if (!grounded) begin
          state_d    = AIRBORNE;
          jump_vel_d = '0;
          armed_d    = 1'b1;
        end else if (!key_space) begin
          state_d    = LAUNCH;
          jump_dir_d = key_dir(key_left, key_right);
        end else if (step_tc) begin
          if (jump_vel_q >= VelMax) begin
`ifdef JUMP_AUTO_LAUNCH_EN
            state_d    = LAUNCH;
            jump_dir_d = key_dir(key_left, key_right);
`else
            jump_vel_d = VelMax;
`endif
          end else begin
            jump_vel_d = jump_vel_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (phys.launch_ack) begin
          state_d = AIRBORNE;
          armed_d = 1'b0;
        end
      end
      AIRBORNE: begin
        if (!grounded) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = LAND;
        end
      end
      LAND: begin
        if (!grounded) begin
          state_d = AIRBORNE;
          armed_d = 1'b1;
        end else if (land_tc) begin
          state_d    = IDLE;
          jump_vel_d = '0;
          jump_dir_d = DIR_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      jump_vel_q   <= '0;
      jump_dir_q   <= DIR_NONE;
      armed_q      <= 1'b0;
      space_rel_q  <= 1'b0;
      launch_req_q <= 1'b0;
      charging_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      jump_vel_q   <= jump_vel_d;
      jump_dir_q   <= jump_dir_d;
      armed_q      <= armed_d;
      space_rel_q  <= ~key_space;
      launch_req_q <= (state_d == LAUNCH);
      charging_q   <= (state_d == CHARGE);
      busy_q       <= (state_d == LAUNCH) || (state_d == AIRBORNE) || (state_d == LAND);
    end
  end

  assign phys.launch_req = launch_req_q;
  assign phys.jump_vel   = jump_vel_q;
  assign phys.jump_dir   = jump_dir_q;
  assign charging        = charging_q;
  assign busy            = busy_q;

endmodule
